// File: rtl/cpu_wb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_master_if
// Purpose  : Bundles the core request/response port and the wishbone master
//            signals of the cpu_wb_master bridge.
//            The master modport is the bridge's view.
//            The slave modport is the core + wishbone slave environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_wb_master_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int SW = 4
);
    // core request / response
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_sel;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    // wishbone master side
    logic [AW-1:0] adr_out;
    logic [DW-1:0] data_out;
    logic          we;
    logic [SW-1:0] sel_out;
    logic          stb_out;
    logic          cyc_out;
    logic [DW-1:0] data_in;
    logic          ack_in;

    modport master (
        input  req_valid, req_we, req_adr, req_wdata, req_sel, data_in, ack_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output adr_out, data_out, we, sel_out, stb_out, cyc_out
    );

    modport slave (
        output req_valid, req_we, req_adr, req_wdata, req_sel, data_in, ack_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  adr_out, data_out, we, sel_out, stb_out, cyc_out
    );
endinterface
`default_nettype wire

// File: rtl/cpu_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_master
// Purpose  : Single-outstanding wishbone master bridging the core's request
//            port. Registers one request, runs a classic cycle, and returns
//            read data or a timeout error as a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_wb_master #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int SW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,   // asynchronous, active-low
    cpu_wb_master_if.master    bus
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TSAT  = {TW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ready;
    logic [TW-1:0] timer;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic          we_q;
    logic [SW-1:0] sel;
    logic [DW-1:0] rdata;
    logic          err;

    logic          accept;
    logic          ack_take;
    logic          timeout_hit;

    // State register; reset drops any cycle in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. Ack takes priority over timeout in the same cycle.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && ready) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (bus.ack_in) begin
                    ack_take   = 1'b1;
                    state_next = RESP;
                end else if (timer == TLAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, wait-state timer and response capture.
    // ready is registered so it stays low during reset and rises one cycle
    // after release rather than being a pure decode of IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
            timer <= '0;
            adr   <= '0;
            wdata <= '0;
            we_q  <= 1'b0;
            sel   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            ready <= (state_next == IDLE);
            if (accept) begin
                adr   <= bus.req_adr;
                wdata <= bus.req_wdata;
                we_q  <= bus.req_we;
                sel   <= bus.req_sel;
                timer <= '0;
            end else if (state == BUS && !bus.ack_in && timer != TSAT) begin
                timer <= timer + TW'(1);
            end
            if (ack_take) begin
                if (!we_q) begin
                    rdata <= bus.data_in;
                end
                err <= 1'b0;
            end else if (timeout_hit) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign bus.adr_out   = adr;
    assign bus.data_out  = wdata;
    assign bus.we        = we_q;
    assign bus.sel_out   = sel;
    assign bus.stb_out   = (state == BUS);
    assign bus.cyc_out   = (state == BUS);

endmodule
`default_nettype wire
